// File: rtl/one_to_eight_demux16bit_reg_if.sv
// Bus bundle for the 1-to-8 registered demux: producer write channel, per-slot acks, slot outputs.
// Carries wr_count only when DEMUX16_WRITE_COUNT_EN is defined.
interface one_to_eight_demux16bit_reg_if #(
  parameter int unsigned WIDTH = 16
);
  logic [2:0]       select;
  logic [WIDTH-1:0] wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       rd_ack;
  logic             flush;
  logic [WIDTH-1:0] q0, q1, q2, q3, q4, q5, q6, q7;
  logic [7:0]       q_full;
`ifdef DEMUX16_WRITE_COUNT_EN
  logic [15:0]      wr_count;
`endif

  modport master (
    output select, wr_data, wr_valid, rd_ack, flush,
    input  wr_ready, q0, q1, q2, q3, q4, q5, q6, q7, q_full
`ifdef DEMUX16_WRITE_COUNT_EN
    , input wr_count
`endif
  );

  modport slave (
    input  select, wr_data, wr_valid, rd_ack, flush,
    output wr_ready, q0, q1, q2, q3, q4, q5, q6, q7, q_full
`ifdef DEMUX16_WRITE_COUNT_EN
    , output wr_count
`endif
  );
endinterface

// File: rtl/one_to_eight_demux16bit_reg.sv
// Routes one word per cycle into one of eight registered slots, each with a full flag cleared by ack.
// Optional accepted-write counter enabled by DEMUX16_WRITE_COUNT_EN.
module one_to_eight_demux16bit_reg #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NSLOT = 8
) (
  input logic                          clock,
  input logic                          reset,
  one_to_eight_demux16bit_reg_if.slave bus
);

  logic [WIDTH-1:0] q_q [NSLOT];
  logic [WIDTH-1:0] q_d [NSLOT];
  logic [NSLOT-1:0] full_q, full_d;
  logic [NSLOT-1:0] wr_sel;
  logic             wr_ready;
  logic             accept;

  // Ack on the selected slot frees it in the same cycle, so writes pass through without a bubble.
  assign wr_ready = ~bus.flush & (~full_q[bus.select] | bus.rd_ack[bus.select]);
  assign accept   = bus.wr_valid & wr_ready;

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NSLOT; i++) begin
      wr_sel[i] = accept && (bus.select == 3'(i));
    end
  end

  always_comb begin
    q_d    = q_q;
    full_d = full_q & ~bus.rd_ack;
    if (bus.flush) begin
      full_d = '0;
    end
    for (int i = 0; i < NSLOT; i++) begin
      if (wr_sel[i]) begin
        q_d[i]    = bus.wr_data;
        full_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        q_q[i] <= '0;
      end
    end else begin
      full_q <= full_d;
      for (int i = 0; i < NSLOT; i++) begin
        q_q[i] <= q_d[i];
      end
    end
  end

`ifdef DEMUX16_WRITE_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Wraps naturally; flush deliberately leaves it alone.
  assign cnt_d = cnt_q + 16'(accept);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.wr_count = cnt_q;
`endif

  assign bus.wr_ready = wr_ready;
  assign bus.q_full   = full_q;
  assign bus.q0       = q_q[0];
  assign bus.q1       = q_q[1];
  assign bus.q2       = q_q[2];
  assign bus.q3       = q_q[3];
  assign bus.q4       = q_q[4];
  assign bus.q5       = q_q[5];
  assign bus.q6       = q_q[6];
  assign bus.q7       = q_q[7];

endmodule

// File: tb/tb_one_to_eight_demux16bit_reg.sv
// Table-driven bench for the 1-to-8 registered demux with a scoreboard of expected slot contents.
// Also covers async reset mid-cycle and, when DEMUX16_WRITE_COUNT_EN is defined, the write counter.
module tb_one_to_eight_demux16bit_reg;

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] data;
    logic        valid;
    logic [7:0]  ack;
    logic        flush;
    logic        exp_ready;
    logic [7:0]  exp_full;
    logic [2:0]  chk_slot;
    logic [15:0] chk_q;
  } vec_t;

  typedef struct {
    logic [2:0]  slot;
    logic [15:0] val;
  } exp_t;

  localparam int NVEC = 19;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   acc_cnt;
  vec_t vecs [NVEC];
  exp_t sb [$];

  one_to_eight_demux16bit_reg_if #(.WIDTH(16)) bus_if ();

  one_to_eight_demux16bit_reg #(
    .WIDTH(16),
    .NSLOT(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] get_q(input logic [2:0] s);
    case (s)
      3'd0: return bus_if.q0;
      3'd1: return bus_if.q1;
      3'd2: return bus_if.q2;
      3'd3: return bus_if.q3;
      3'd4: return bus_if.q4;
      3'd5: return bus_if.q5;
      3'd6: return bus_if.q6;
      default: return bus_if.q7;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] sel, input logic [15:0] data, input logic valid,
                              input logic [7:0] ack, input logic flush, input logic exp_ready,
                              input logic [7:0] exp_full, input logic [2:0] chk_slot,
                              input logic [15:0] chk_q);
    vec_t v;
    v.sel = sel; v.data = data; v.valid = valid; v.ack = ack; v.flush = flush;
    v.exp_ready = exp_ready; v.exp_full = exp_full; v.chk_slot = chk_slot; v.chk_q = chk_q;
    return v;
  endfunction

  task automatic drive(input logic [2:0] sel, input logic [15:0] data, input logic valid,
                       input logic [7:0] ack, input logic flush);
    bus_if.select   = sel;
    bus_if.wr_data  = data;
    bus_if.wr_valid = valid;
    bus_if.rd_ack   = ack;
    bus_if.flush    = flush;
  endtask

  initial begin
    exp_t e;
    checks  = 0;
    errors  = 0;
    acc_cnt = 0;

    //          sel   data      vld ack    fl rdy full   slot  q
    vecs[0]  = mk(3'd3, 16'hA5A5, 1, 8'h00, 0, 1, 8'h08, 3'd3, 16'hA5A5);
    vecs[1]  = mk(3'd2, 16'h1111, 1, 8'h00, 0, 1, 8'h0C, 3'd2, 16'h1111);
    vecs[2]  = mk(3'd2, 16'h2222, 1, 8'h00, 0, 0, 8'h0C, 3'd2, 16'h1111);
    vecs[3]  = mk(3'd2, 16'h2222, 1, 8'h04, 0, 1, 8'h0C, 3'd2, 16'h2222);
    vecs[4]  = mk(3'd5, 16'h5555, 1, 8'h00, 0, 1, 8'h2C, 3'd5, 16'h5555);
    vecs[5]  = mk(3'd0, 16'h0007, 1, 8'h20, 0, 1, 8'h0D, 3'd5, 16'h5555);
    vecs[6]  = mk(3'd0, 16'h0000, 0, 8'h00, 0, 0, 8'h0D, 3'd0, 16'h0007);
    vecs[7]  = mk(3'd1, 16'h0000, 0, 8'h02, 0, 1, 8'h0D, 3'd1, 16'h0000);
    vecs[8]  = mk(3'd4, 16'hBEEF, 1, 8'h01, 1, 0, 8'h00, 3'd4, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      vecs[9 + i] = mk(3'(i), 16'(i), 1, 8'h00, 0, 1, 8'((2 << i) - 1), 3'(i), 16'(i));
    end
    vecs[17] = mk(3'd1, 16'hFFFF, 1, 8'h00, 1, 0, 8'h00, 3'd1, 16'h0001);
    vecs[18] = mk(3'd3, 16'h0000, 0, 8'h00, 0, 1, 8'h00, 3'd3, 16'h0003);

    drive(3'd0, 16'h0000, 0, 8'h00, 0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    check("reset_q_full", 32'(bus_if.q_full), 32'h00);
    for (int s = 0; s < 8; s++) check($sformatf("reset_q%0d", s), 32'(get_q(3'(s))), 32'h0);
    check("reset_wr_ready", 32'(bus_if.wr_ready), 32'h1);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].sel, vecs[i].data, vecs[i].valid, vecs[i].ack, vecs[i].flush);
      e.slot = vecs[i].chk_slot;
      e.val  = vecs[i].chk_q;
      sb.push_back(e);
      #1;
      check($sformatf("v%0d_wr_ready", i), 32'(bus_if.wr_ready), 32'(vecs[i].exp_ready));
      if (vecs[i].valid && vecs[i].exp_ready) acc_cnt++;
      @(posedge clock);
      #1;
      check($sformatf("v%0d_q_full", i), 32'(bus_if.q_full), 32'(vecs[i].exp_full));
      e = sb.pop_front();
      check($sformatf("v%0d_q%0d", i, e.slot), 32'(get_q(e.slot)), 32'(e.val));
    end

    // Async reset mid-cycle with slots full: everything must clear before the next edge.
    for (int i = 0; i < 3; i++) begin
      drive(3'(i), 16'h1000 + 16'(i), 1, 8'h00, 0);
      @(posedge clock);
      #1;
    end
    drive(3'd0, 16'h0000, 0, 8'h00, 0);
    check("prereset_q_full", 32'(bus_if.q_full), 32'h07);
    #2 reset = 1'b1;
    #1;
    check("async_q_full", 32'(bus_if.q_full), 32'h00);
    for (int s = 0; s < 8; s++) check($sformatf("async_q%0d", s), 32'(get_q(3'(s))), 32'h0);
    @(negedge clock);
    reset   = 1'b0;
    acc_cnt = 0;

    // Producer retries after reset.
    drive(3'd6, 16'h6666, 1, 8'h00, 0);
    e.slot = 3'd6;
    e.val  = 16'h6666;
    sb.push_back(e);
    #1 check("retry_wr_ready", 32'(bus_if.wr_ready), 32'h1);
    acc_cnt++;
    @(posedge clock);
    #1;
    drive(3'd0, 16'h0000, 0, 8'h00, 0);
    check("retry_q_full", 32'(bus_if.q_full), 32'h40);
    e = sb.pop_front();
    check("retry_q6", 32'(get_q(e.slot)), 32'(e.val));

`ifdef DEMUX16_WRITE_COUNT_EN
    check("wr_count", 32'(bus_if.wr_count), 32'(acc_cnt));
    // Slot 6 is full: a rejected write must not count.
    drive(3'd6, 16'h7777, 1, 8'h00, 0);
    @(posedge clock);
    #1;
    drive(3'd0, 16'h0000, 0, 8'h00, 0);
    check("wr_count_rejected", 32'(bus_if.wr_count), 32'(acc_cnt));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
